// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the two-port DDR FIFO command arbiter.
package fifo_arb_pkg;

   localparam logic CMD_WT = 1'b0;
   localparam logic CMD_RD = 1'b1;

   localparam int unsigned ADDR_W  = 27;
   localparam int unsigned BURST_W = 6;
   localparam int unsigned DATA_W  = 128;
   localparam int unsigned MASK_W  = 16;

   // Outstanding-read record: issuing port and beats-1 of the burst
   typedef struct packed {
      logic               port;
      logic [BURST_W-1:0] burst_cnt;
   } tag_t;

   typedef enum logic {
      STG_EMPTY = 1'b0,
      STG_FULL  = 1'b1
   } stage_e;

endpackage

// File: rtl/fifo_arb_tag_fifo.sv
// In-order tag FIFO holding {port, burst_cnt} for every accepted read.
// Push and pop in the same cycle are both honoured, including when full.
module fifo_arb_tag_fifo
   import fifo_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  tag_t push_tag,
   input  logic pop,
   output logic full,
   output logic empty,
   output tag_t head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   tag_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)      count <= count + 1'b1;
         else if (pop_ok && !push_ok) count <= count - 1'b1;
      end
   end

   // Tag storage; contents are only meaningful between push and pop
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_tag;
   end

endmodule

// File: rtl/fifo_cmd_arbiter.sv
// Two-port arbiter in front of the DDR FIFO command/response interface.
// Optional macro FIFO_ARB_RR_EN: round-robin arbitration; otherwise port 0
// has fixed priority.
module fifo_cmd_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned OUTSTD_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,

   input  logic               m0_cmd_valid,
   output logic               m0_cmd_ready,
   input  logic               m0_cmd_type,
   input  logic [ADDR_W-1:0]  m0_cmd_addr,
   input  logic [BURST_W-1:0] m0_cmd_burst_cnt,
   input  logic [DATA_W-1:0]  m0_cmd_wt_data,
   input  logic [MASK_W-1:0]  m0_cmd_wt_mask,
   output logic               m0_rsp_valid,
   output logic [DATA_W-1:0]  m0_rsp_data,

   input  logic               m1_cmd_valid,
   output logic               m1_cmd_ready,
   input  logic               m1_cmd_type,
   input  logic [ADDR_W-1:0]  m1_cmd_addr,
   input  logic [BURST_W-1:0] m1_cmd_burst_cnt,
   input  logic [DATA_W-1:0]  m1_cmd_wt_data,
   input  logic [MASK_W-1:0]  m1_cmd_wt_mask,
   output logic               m1_rsp_valid,
   output logic [DATA_W-1:0]  m1_rsp_data,

   output logic               io_fifo_cmd_valid,
   input  logic               io_fifo_cmd_ready,
   output logic               io_fifo_cmd_type,
   output logic [ADDR_W-1:0]  io_fifo_cmd_addr,
   output logic [BURST_W-1:0] io_fifo_cmd_burst_cnt,
   output logic [DATA_W-1:0]  io_fifo_cmd_wt_data,
   output logic [MASK_W-1:0]  io_fifo_cmd_wt_mask,
   input  logic               io_fifo_rsp_valid,
   output logic               io_fifo_rsp_ready,
   input  logic [DATA_W-1:0]  io_fifo_rsp_data,

   output logic               err_orphan_rsp
);

   stage_e             stage_q;
   logic               tag_full;
   logic               tag_empty;
   tag_t               tag_head;
   logic               tag_push;
   logic               tag_pop;
   tag_t               push_tag;
   logic [BURST_W-1:0] beat_cnt;
   logic               rsp_hit;
   logic               tag_room;
   logic               can_load;
   logic               elig0;
   logic               elig1;
   logic               grant0;
   logic               grant1;
   logic               sel_type;
   logic [ADDR_W-1:0]  sel_addr;
   logic [BURST_W-1:0] sel_burst;
   logic [DATA_W-1:0]  sel_data;
   logic [MASK_W-1:0]  sel_mask;

   // Response-side tag consumption; a pop frees a slot for a read in the same cycle
   assign rsp_hit  = io_fifo_rsp_valid && !tag_empty;
   assign tag_pop  = rsp_hit && (beat_cnt == tag_head.burst_cnt);
   assign tag_room = !tag_full || tag_pop;

   assign can_load = (stage_q == STG_EMPTY) || io_fifo_cmd_ready;
   assign elig0    = m0_cmd_valid && ((m0_cmd_type == CMD_WT) || tag_room);
   assign elig1    = m1_cmd_valid && ((m1_cmd_type == CMD_WT) || tag_room);

`ifdef FIFO_ARB_RR_EN
   logic rr_prio_q;  // 1: port 1 preferred on contention

   // Priority flips to the port that did not win the most recent grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         rr_prio_q <= 1'b0;
      else if (grant0) rr_prio_q <= 1'b1;
      else if (grant1) rr_prio_q <= 1'b0;
   end
`endif

   // Pick one eligible port whenever the output stage can take a command
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (can_load) begin
`ifdef FIFO_ARB_RR_EN
         if (elig0 && elig1) begin
            grant0 = !rr_prio_q;
            grant1 = rr_prio_q;
         end else begin
            grant0 = elig0;
            grant1 = elig1;
         end
`else
         grant0 = elig0;
         grant1 = elig1 && !elig0;
`endif
      end
   end

   assign m0_cmd_ready = grant0;
   assign m1_cmd_ready = grant1;

   // Winner's command fields
   always_comb begin
      sel_type  = m0_cmd_type;
      sel_addr  = m0_cmd_addr;
      sel_burst = m0_cmd_burst_cnt;
      sel_data  = m0_cmd_wt_data;
      sel_mask  = m0_cmd_wt_mask;
      if (grant1) begin
         sel_type  = m1_cmd_type;
         sel_addr  = m1_cmd_addr;
         sel_burst = m1_cmd_burst_cnt;
         sel_data  = m1_cmd_wt_data;
         sel_mask  = m1_cmd_wt_mask;
      end
   end

   assign tag_push = (grant0 || grant1) && (sel_type == CMD_RD);
   assign push_tag = '{port: grant1, burst_cnt: sel_burst};

   // One-entry output stage: loads on grant, drains on downstream ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q               <= STG_EMPTY;
         io_fifo_cmd_type      <= 1'b0;
         io_fifo_cmd_addr      <= '0;
         io_fifo_cmd_burst_cnt <= '0;
         io_fifo_cmd_wt_data   <= '0;
         io_fifo_cmd_wt_mask   <= '0;
      end else if (grant0 || grant1) begin
         stage_q               <= STG_FULL;
         io_fifo_cmd_type      <= sel_type;
         io_fifo_cmd_addr      <= sel_addr;
         io_fifo_cmd_burst_cnt <= sel_burst;
         io_fifo_cmd_wt_data   <= sel_data;
         io_fifo_cmd_wt_mask   <= sel_mask;
      end else if (io_fifo_cmd_ready) begin
         stage_q <= STG_EMPTY;
      end
   end

   assign io_fifo_cmd_valid = (stage_q == STG_FULL);

   // Beat counter within the burst at the head of the tag FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          beat_cnt <= '0;
      else if (tag_pop) beat_cnt <= '0;
      else if (rsp_hit) beat_cnt <= beat_cnt + 1'b1;
   end

   // Sticky flag for response beats that have no outstanding read
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  err_orphan_rsp <= 1'b0;
      else if (io_fifo_rsp_valid && tag_empty) err_orphan_rsp <= 1'b1;
   end

   assign io_fifo_rsp_ready = 1'b1;
   assign m0_rsp_valid      = rsp_hit && (tag_head.port == 1'b0);
   assign m1_rsp_valid      = rsp_hit && (tag_head.port == 1'b1);
   assign m0_rsp_data       = io_fifo_rsp_data;
   assign m1_rsp_data       = io_fifo_rsp_data;

   fifo_arb_tag_fifo #(
      .DEPTH (OUTSTD_DEPTH)
   ) u_tag_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (tag_push),
      .push_tag (push_tag),
      .pop      (tag_pop),
      .full     (tag_full),
      .empty    (tag_empty),
      .head     (tag_head)
   );

endmodule

// File: tb/tb_fifo_cmd_arbiter.sv
// Self-checking bench for fifo_cmd_arbiter: directed scenarios plus a
// randomized run against a queue-based transaction model.
module tb_fifo_cmd_arbiter;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         m0_cmd_valid, m0_cmd_ready, m0_cmd_type;
   logic [26:0]  m0_cmd_addr;
   logic [5:0]   m0_cmd_burst_cnt;
   logic [127:0] m0_cmd_wt_data;
   logic [15:0]  m0_cmd_wt_mask;
   logic         m0_rsp_valid;
   logic [127:0] m0_rsp_data;
   logic         m1_cmd_valid, m1_cmd_ready, m1_cmd_type;
   logic [26:0]  m1_cmd_addr;
   logic [5:0]   m1_cmd_burst_cnt;
   logic [127:0] m1_cmd_wt_data;
   logic [15:0]  m1_cmd_wt_mask;
   logic         m1_rsp_valid;
   logic [127:0] m1_rsp_data;
   logic         io_fifo_cmd_valid, io_fifo_cmd_ready, io_fifo_cmd_type;
   logic [26:0]  io_fifo_cmd_addr;
   logic [5:0]   io_fifo_cmd_burst_cnt;
   logic [127:0] io_fifo_cmd_wt_data;
   logic [15:0]  io_fifo_cmd_wt_mask;
   logic         io_fifo_rsp_valid, io_fifo_rsp_ready;
   logic [127:0] io_fifo_rsp_data;
   logic         err_orphan_rsp;

   int n_tests = 0;
   int n_fail  = 0;

   fifo_cmd_arbiter #(.OUTSTD_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_type(m0_cmd_type),
      .m0_cmd_addr(m0_cmd_addr), .m0_cmd_burst_cnt(m0_cmd_burst_cnt),
      .m0_cmd_wt_data(m0_cmd_wt_data), .m0_cmd_wt_mask(m0_cmd_wt_mask),
      .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
      .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_type(m1_cmd_type),
      .m1_cmd_addr(m1_cmd_addr), .m1_cmd_burst_cnt(m1_cmd_burst_cnt),
      .m1_cmd_wt_data(m1_cmd_wt_data), .m1_cmd_wt_mask(m1_cmd_wt_mask),
      .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
      .io_fifo_cmd_valid(io_fifo_cmd_valid), .io_fifo_cmd_ready(io_fifo_cmd_ready),
      .io_fifo_cmd_type(io_fifo_cmd_type), .io_fifo_cmd_addr(io_fifo_cmd_addr),
      .io_fifo_cmd_burst_cnt(io_fifo_cmd_burst_cnt), .io_fifo_cmd_wt_data(io_fifo_cmd_wt_data),
      .io_fifo_cmd_wt_mask(io_fifo_cmd_wt_mask), .io_fifo_rsp_valid(io_fifo_rsp_valid),
      .io_fifo_rsp_ready(io_fifo_rsp_ready), .io_fifo_rsp_data(io_fifo_rsp_data),
      .err_orphan_rsp(err_orphan_rsp)
   );

   always #5 clk = ~clk;

   // ---------------- transaction-level reference model ----------------
   typedef struct { int port; int burst; } mtag_t;
   mtag_t        mq[$];          // outstanding reads in issue order
   int           mbeat;          // beats already returned for mq[0]
   bit           mst_full;
   logic         mtype;
   logic [26:0]  maddr;
   logic [5:0]   mburst;
   logic [127:0] mdata;
   logic [15:0]  mmask;
   bit           merr;
   int           mlast;          // port of the most recent grant
   int           exp_win;        // -1: no grant this cycle
   bit           exp_rv0, exp_rv1;

   task automatic model_reset();
      mq.delete();
      mbeat = 0; mst_full = 0; merr = 0; mlast = 1;
      mtype = 1'b0; maddr = '0; mburst = '0; mdata = '0; mmask = '0;
   endtask

   task automatic model_comb();
      bit pop, room, can, e0, e1;
      pop = 0;
      if (io_fifo_rsp_valid && mq.size() > 0) pop = (mbeat == mq[0].burst);
      room = (mq.size() < DEPTH) || pop;
      can  = !mst_full || io_fifo_cmd_ready;
      e0   = m0_cmd_valid && (!m0_cmd_type || room);
      e1   = m1_cmd_valid && (!m1_cmd_type || room);
      exp_win = -1;
      if (can) begin
         if (e0 && e1) begin
`ifdef FIFO_ARB_RR_EN
            exp_win = (mlast == 0) ? 1 : 0;
`else
            exp_win = 0;
`endif
         end else if (e0) exp_win = 0;
         else if (e1)     exp_win = 1;
      end
      exp_rv0 = 0; exp_rv1 = 0;
      if (io_fifo_rsp_valid && mq.size() > 0) begin
         exp_rv0 = (mq[0].port == 0);
         exp_rv1 = (mq[0].port == 1);
      end
   endtask

   task automatic model_edge();
      if (io_fifo_rsp_valid) begin
         if (mq.size() == 0) merr = 1;
         else if (mbeat == mq[0].burst) begin
            void'(mq.pop_front());
            mbeat = 0;
         end else mbeat++;
      end
      if (exp_win >= 0) begin
         mst_full = 1;
         mlast    = exp_win;
         mtype  = exp_win ? m1_cmd_type      : m0_cmd_type;
         maddr  = exp_win ? m1_cmd_addr      : m0_cmd_addr;
         mburst = exp_win ? m1_cmd_burst_cnt : m0_cmd_burst_cnt;
         mdata  = exp_win ? m1_cmd_wt_data   : m0_cmd_wt_data;
         mmask  = exp_win ? m1_cmd_wt_mask   : m0_cmd_wt_mask;
         if (mtype) mq.push_back('{port: exp_win, burst: int'(mburst)});
      end else if (io_fifo_cmd_ready) mst_full = 0;
   endtask

   // Advance one clock, keeping the model in step; returns at posedge+1
   task automatic tick();
      model_comb();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic clear_inputs();
      m0_cmd_valid = 0; m0_cmd_type = 0; m0_cmd_addr = '0; m0_cmd_burst_cnt = '0;
      m0_cmd_wt_data = '0; m0_cmd_wt_mask = '0;
      m1_cmd_valid = 0; m1_cmd_type = 0; m1_cmd_addr = '0; m1_cmd_burst_cnt = '0;
      m1_cmd_wt_data = '0; m1_cmd_wt_mask = '0;
      io_fifo_cmd_ready = 1; io_fifo_rsp_valid = 0; io_fifo_rsp_data = '0;
   endtask

   task automatic do_reset();
      rst = 1;
      clear_inputs();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      #1;
      n_tests++;
      if ({io_fifo_cmd_valid, io_fifo_cmd_type, io_fifo_cmd_addr, io_fifo_cmd_burst_cnt,
           io_fifo_cmd_wt_data, io_fifo_cmd_wt_mask} !== '0) begin
         n_fail++;
         $display("FAIL reset_stage: valid=%b addr=%h burst=%h required all zero",
                  io_fifo_cmd_valid, io_fifo_cmd_addr, io_fifo_cmd_burst_cnt);
      end
      n_tests++;
      if ({m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, err_orphan_rsp, io_fifo_rsp_ready} !== 6'b000001) begin
         n_fail++;
         $display("FAIL reset_ctrl: rdy=%b%b rsp=%b%b err=%b rsp_ready=%b required 000001",
                  m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, err_orphan_rsp, io_fifo_rsp_ready);
      end
   endtask

   task automatic test_single_read();
      do_reset();
      m0_cmd_valid = 1; m0_cmd_type = 1; m0_cmd_addr = 27'h0000100; m0_cmd_burst_cnt = 0;
      #1;
      n_tests++;
      if ({m0_cmd_ready, m1_cmd_ready} !== 2'b10) begin
         n_fail++; $display("FAIL single_ready: m0=%b m1=%b required 1 0", m0_cmd_ready, m1_cmd_ready);
      end
      tick();
      m0_cmd_valid = 0;
      n_tests++;
      if ({io_fifo_cmd_valid, io_fifo_cmd_type, io_fifo_cmd_addr} !== {1'b1, 1'b1, 27'h0000100}) begin
         n_fail++; $display("FAIL single_issue: valid=%b type=%b addr=%h required 1 1 0000100",
                            io_fifo_cmd_valid, io_fifo_cmd_type, io_fifo_cmd_addr);
      end
      io_fifo_rsp_valid = 1; io_fifo_rsp_data = {4{32'hA5A5A5A5}};
      #1;
      n_tests++;
      if ({m0_rsp_valid, m1_rsp_valid} !== 2'b10 || m0_rsp_data !== {4{32'hA5A5A5A5}}) begin
         n_fail++; $display("FAIL single_rsp: m0_v=%b m1_v=%b data=%h required 1 0 a5..a5",
                            m0_rsp_valid, m1_rsp_valid, m0_rsp_data);
      end
      tick();
      io_fifo_rsp_valid = 0;
      n_tests++;
      if ({io_fifo_cmd_valid, m0_rsp_valid} !== 2'b00) begin
         n_fail++; $display("FAIL single_drain: cmd_valid=%b m0_rsp=%b required 0 0", io_fifo_cmd_valid, m0_rsp_valid);
      end
   endtask

   task automatic test_arb();
      do_reset();
      m0_cmd_valid = 1; m0_cmd_type = 0; m0_cmd_addr = 27'h0001000;
      m1_cmd_valid = 1; m1_cmd_type = 0; m1_cmd_addr = 27'h0002000;
      for (int i = 0; i < 8; i++) begin
         int exp_p;
`ifdef FIFO_ARB_RR_EN
         exp_p = i % 2;
`else
         exp_p = 0;
`endif
         #1;
         n_tests++;
         if ({m1_cmd_ready, m0_cmd_ready} !== (exp_p ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL arb_grant[%0d]: m0=%b m1=%b required port %0d", i, m0_cmd_ready, m1_cmd_ready, exp_p);
         end
         tick();
         n_tests++;
         if (io_fifo_cmd_addr !== (exp_p ? 27'h0002000 : 27'h0001000)) begin
            n_fail++; $display("FAIL arb_addr[%0d]: got %h required port %0d addr", i, io_fifo_cmd_addr, exp_p);
         end
      end
      clear_inputs();
   endtask

   task automatic test_burst();
      do_reset();
      m1_cmd_valid = 1; m1_cmd_type = 1; m1_cmd_addr = 27'h0000200; m1_cmd_burst_cnt = 3;
      #1;
      n_tests++;
      if (m1_cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL burst_m1_ready: got %b required 1", m1_cmd_ready);
      end
      tick();
      m1_cmd_valid = 0;
      m0_cmd_valid = 1; m0_cmd_type = 1; m0_cmd_addr = 27'h0000300; m0_cmd_burst_cnt = 0;
      tick();
      m0_cmd_valid = 0;
      for (int b = 0; b < 5; b++) begin
         io_fifo_rsp_valid = 1; io_fifo_rsp_data = 128'(b + 1);
         #1;
         n_tests++;
         if ({m1_rsp_valid, m0_rsp_valid} !== ((b < 4) ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL burst_route[%0d]: m0=%b m1=%b required %s", b, m0_rsp_valid, m1_rsp_valid,
                               (b < 4) ? "m1" : "m0");
         end
         tick();
      end
      io_fifo_rsp_valid = 0;
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m0_cmd_valid = 1; m0_cmd_type = 1; m0_cmd_burst_cnt = 0; m0_cmd_addr = 27'h400 + 27'(16 * i);
         #1;
         n_tests++;
         if (m0_cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_fill[%0d]: ready=%b required 1", i, m0_cmd_ready);
         end
         tick();
      end
      m0_cmd_addr = 27'h0000500;
      m1_cmd_valid = 1; m1_cmd_type = 0; m1_cmd_addr = 27'h0000600;
      #1;
      n_tests++;
      if ({m0_cmd_ready, m1_cmd_ready} !== 2'b01) begin
         n_fail++; $display("FAIL full_stall: m0=%b m1=%b required 0 1", m0_cmd_ready, m1_cmd_ready);
      end
      tick();
      m1_cmd_valid = 0;
      io_fifo_rsp_valid = 1; io_fifo_rsp_data = 128'h5;
      #1;
      n_tests++;
      if ({m0_cmd_ready, m0_rsp_valid} !== 2'b11) begin
         n_fail++; $display("FAIL full_pop_accept: ready=%b rsp=%b required 1 1", m0_cmd_ready, m0_rsp_valid);
      end
      tick();
      io_fifo_rsp_valid = 0; m0_cmd_valid = 0;
      n_tests++;
      if (io_fifo_cmd_addr !== 27'h0000500) begin
         n_fail++; $display("FAIL full_fifth_addr: got %h required 0000500", io_fifo_cmd_addr);
      end
   endtask

   task automatic test_stall();
      logic [127:0] d0;
      do_reset();
      d0 = {$urandom, $urandom, $urandom, $urandom};
      io_fifo_cmd_ready = 0;
      m0_cmd_valid = 1; m0_cmd_type = 0; m0_cmd_addr = 27'h0000700; m0_cmd_wt_data = d0;
      tick();
      m0_cmd_addr = 27'h0000710; m0_cmd_wt_data = ~d0;
      m1_cmd_valid = 1; m1_cmd_type = 0; m1_cmd_addr = 27'h0000720;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_tests++;
         if ({m0_cmd_ready, m1_cmd_ready} !== 2'b00) begin
            n_fail++; $display("FAIL stall_ready[%0d]: m0=%b m1=%b required 0 0", i, m0_cmd_ready, m1_cmd_ready);
         end
         tick();
         n_tests++;
         if ({io_fifo_cmd_valid, io_fifo_cmd_addr, io_fifo_cmd_wt_data} !== {1'b1, 27'h0000700, d0}) begin
            n_fail++; $display("FAIL stall_hold[%0d]: valid=%b addr=%h required 1 0000700", i, io_fifo_cmd_valid, io_fifo_cmd_addr);
         end
      end
      io_fifo_cmd_ready = 1;
      #1;
      n_tests++;
`ifdef FIFO_ARB_RR_EN
      if ({m0_cmd_ready, m1_cmd_ready} !== 2'b01) begin
         n_fail++; $display("FAIL stall_b2b: m0=%b m1=%b required 0 1", m0_cmd_ready, m1_cmd_ready);
      end
`else
      if ({m0_cmd_ready, m1_cmd_ready} !== 2'b10) begin
         n_fail++; $display("FAIL stall_b2b: m0=%b m1=%b required 1 0", m0_cmd_ready, m1_cmd_ready);
      end
`endif
      tick();
      clear_inputs();
   endtask

   task automatic test_orphan();
      do_reset();
      io_fifo_rsp_valid = 1;
      #1;
      n_tests++;
      if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin
         n_fail++; $display("FAIL orphan_route: m0=%b m1=%b required 0 0", m0_rsp_valid, m1_rsp_valid);
      end
      tick();
      io_fifo_rsp_valid = 0;
      repeat (3) tick();
      n_tests++;
      if (err_orphan_rsp !== 1'b1) begin
         n_fail++; $display("FAIL orphan_sticky: err=%b required 1", err_orphan_rsp);
      end
      m1_cmd_valid = 1; m1_cmd_type = 1; m1_cmd_addr = 27'h0000800; m1_cmd_burst_cnt = 3;
      tick();
      m1_cmd_valid = 0;
      io_fifo_rsp_valid = 1;
      tick();
      tick();
      rst = 1;
      #1;
      n_tests++;
      if ({io_fifo_cmd_valid, io_fifo_cmd_addr, io_fifo_cmd_burst_cnt, io_fifo_cmd_type,
           m0_rsp_valid, m1_rsp_valid, err_orphan_rsp, m0_cmd_ready, m1_cmd_ready} !== '0) begin
         n_fail++; $display("FAIL midburst_reset: valid=%b addr=%h m1_rsp=%b err=%b required all zero",
                            io_fifo_cmd_valid, io_fifo_cmd_addr, m1_rsp_valid, err_orphan_rsp);
      end
      model_reset();
      @(posedge clk);
      #1 rst = 0;
      #1;
      n_tests++;
      if (m1_rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_orphan: m1_rsp=%b required 0", m1_rsp_valid);
      end
      tick();
      io_fifo_rsp_valid = 0;
      n_tests++;
      if (err_orphan_rsp !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_err: err=%b required 1", err_orphan_rsp);
      end
   endtask

   task automatic test_random();
      int fails_before;
      fails_before = n_fail;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         // a port that is idle or was just granted may present a new command
         if (!m0_cmd_valid || exp_win == 0) begin
            m0_cmd_valid = ($urandom % 3) != 0; m0_cmd_type = 1'($urandom);
            m0_cmd_addr = 27'($urandom) & ~27'hF; m0_cmd_burst_cnt = 6'($urandom % 4);
            m0_cmd_wt_data = {$urandom, $urandom, $urandom, $urandom}; m0_cmd_wt_mask = 16'($urandom);
         end
         if (!m1_cmd_valid || exp_win == 1) begin
            m1_cmd_valid = ($urandom % 3) != 0; m1_cmd_type = 1'($urandom);
            m1_cmd_addr = 27'($urandom) & ~27'hF; m1_cmd_burst_cnt = 6'($urandom % 4);
            m1_cmd_wt_data = {$urandom, $urandom, $urandom, $urandom}; m1_cmd_wt_mask = 16'($urandom);
         end
         io_fifo_cmd_ready = ($urandom % 4) != 0;
         io_fifo_rsp_valid = (mq.size() > 0) ? 1'($urandom) : (($urandom % 40) == 0);
         io_fifo_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
         #1;
         model_comb();
         n_tests++;
         if ({m0_cmd_ready, m1_cmd_ready} !== {exp_win == 0, exp_win == 1} ||
             {m0_rsp_valid, m1_rsp_valid} !== {exp_rv0, exp_rv1} ||
             m0_rsp_data !== io_fifo_rsp_data || m1_rsp_data !== io_fifo_rsp_data) begin
            n_fail++;
            if (n_fail - fails_before < 10)
               $display("FAIL rand_comb[%0d]: rdy=%b%b rsp=%b%b required win=%0d rsp=%b%b",
                        c, m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, exp_win, exp_rv0, exp_rv1);
         end
         tick();
         n_tests++;
         if ({io_fifo_cmd_valid, io_fifo_cmd_type, io_fifo_cmd_addr, io_fifo_cmd_burst_cnt,
              io_fifo_cmd_wt_data, io_fifo_cmd_wt_mask, err_orphan_rsp} !==
             {mst_full, mtype, maddr, mburst, mdata, mmask, merr}) begin
            n_fail++;
            if (n_fail - fails_before < 10)
               $display("FAIL rand_stage[%0d]: valid=%b type=%b addr=%h burst=%h err=%b required %b %b %h %h %b",
                        c, io_fifo_cmd_valid, io_fifo_cmd_type, io_fifo_cmd_addr, io_fifo_cmd_burst_cnt,
                        err_orphan_rsp, mst_full, mtype, maddr, mburst, merr);
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      model_reset();
      exp_win = -1;
      test_reset();
      test_single_read();
      test_arb();
      test_burst();
      test_full();
      test_stall();
      test_orphan();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_cmd_arbiter.md
# fifo_cmd_arbiter

Two-port arbiter that shares the single 128-bit DDR FIFO command/response interface (io_fifo_cmd_*, io_fifo_rsp_*) between two upstream masters, e.g. the AXI4 line cache and a DMA/boot loader. It registers the granted command into a one-entry output stage and records each read's issuer and beat count in an in-order tag FIFO. It steers every response beat back to the port that issued the read. It sits directly between the requesters and the DDR FIFO controller.

## Interface
- OUTSTD_DEPTH, 4: maximum outstanding read commands (tag FIFO depth, power of two, ≥2).
- clk  in  1  system clock (27 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- mN_cmd_valid / mN_cmd_ready  in/out  1  per-port command handshake, N ∈ {0,1}.
- mN_cmd_type  in  1  0 = write, 1 = read.
- mN_cmd_addr  in  27  byte address, 16-byte aligned.
- mN_cmd_burst_cnt  in  6  beats − 1.
- mN_cmd_wt_data  in  128  write data.
- mN_cmd_wt_mask  in  16  write byte mask, 1 = masked.
- mN_rsp_valid  out  1  response beat for port N; no backpressure.
- mN_rsp_data  out  128  response data.
- io_fifo_cmd_valid / io_fifo_cmd_ready  out/in  1  downstream handshake.
- io_fifo_cmd_type, _addr, _burst_cnt, _wt_data, _wt_mask  out  1/27/6/128/16  registered command.
- io_fifo_rsp_valid  in  1  response beat.
- io_fifo_rsp_ready  out  1  tied 1.
- io_fifo_rsp_data  in  128  response data.
- err_orphan_rsp  out  1  sticky: a response beat arrived with the tag FIFO empty.

## Operation
- Output stage states: EMPTY and FULL. The stage can load when EMPTY, or when FULL and io_fifo_cmd_ready is high in the same cycle (back-to-back).
- Eligibility: a port is eligible when mN_cmd_valid is high and, if the command is a read, the tag FIFO is not full.
  - A read accepted in the same cycle a tag pops counts against the post-pop occupancy.
- Arbitration: when the stage can load, the arbiter picks one eligible port.
  - The winner gets mN_cmd_ready=1 for that cycle only, and its fields are copied into the stage.
  - The loser's mN_cmd_ready stays 0.
- mN_cmd_ready is combinational from valid, the stage state and the tag FIFO state. Upstream must hold its command stable until ready.
- On a read accept, push {port, burst_cnt} into the tag FIFO at the same edge the stage loads. The push happens at accept, not at downstream issue, so a tag always precedes its response.
- Response routing:
  - mN_rsp_valid = io_fifo_rsp_valid && tag_head.port == N.
  - mN_rsp_data = io_fifo_rsp_data for both ports.
  - A beat counter counts up from 0. On the beat where the counter equals tag_head.burst_cnt, pop the tag and clear the counter.
- Orphan response (io_fifo_rsp_valid with tag FIFO empty): drop the beat, assert no mN_rsp_valid, set err_orphan_rsp. Only rst clears it.
- Writes create no tag and produce no response.

## Timing
- Reset values:
  - Stage EMPTY; io_fifo_cmd_valid=0; all io_fifo_cmd_* data outputs 0.
  - mN_cmd_ready=0 and mN_rsp_valid=0.
  - Tag FIFO empty; beat counter 0; round-robin pointer favours port 0; err_orphan_rsp=0.
- Latency: a command accepted at edge k drives io_fifo_cmd_valid=1 from edge k onward. Downstream sees it 1 cycle after upstream valid when the stage is free.
- Throughput: 1 command/cycle while io_fifo_cmd_ready stays high.
- The stage holds all fields stable while valid && !ready.
- Response steering is zero-latency (combinational).
- Tag push and pop in the same cycle: occupancy is unchanged and both take effect.
- Reset mid-operation discards the pending command and all tags. Any responses still in flight afterwards are orphans.

## Configuration
- FIFO_ARB_RR_EN defined:
  - Round-robin arbitration. Priority goes to the port that did not win the last grant.
  - The pointer updates only on a grant.
- Undefined:
  - Fixed priority, port 0 always wins. The pointer register is not built.

## Structure
- Shared package fifo_arb_pkg holds:
  - CMD_WT=1'b0, CMD_RD=1'b1.
  - The 27-bit address, 6-bit burst and 128-bit data width constants.
  - A packed tag struct {port, burst_cnt}.
- One sub-module, fifo_arb_tag_fifo: synchronous FIFO, OUTSTD_DEPTH entries, with push/pop/full/empty/head, same clk/rst.

## Test plan
- Only m0 issues a read at addr 0x0000100, burst 0 → io_fifo_cmd_valid the next cycle with type=1, addr=0x0000100. Response beat 0xA5..A5 → m0_rsp_valid for 1 cycle, m1_rsp_valid=0.
- Both ports valid every cycle, ready always 1:
  - With FIFO_ARB_RR_EN, grants alternate 0,1,0,1.
  - Without it, all grants go to m0.
- m1 read with burst_cnt=3 → m1_rsp_valid for 4 beats; the tag pops on the 4th. A following m0 read's response then routes to m0.
- Issue 4 reads with no responses → a 5th read stalls (ready=0) while a write from the other port is still granted. One response pops a tag → the 5th read is accepted the same cycle.
- io_fifo_cmd_ready held 0 for 5 cycles → the stage fields stay constant and no upstream ready is asserted. Ready rises → back-to-back accept.
- io_fifo_rsp_valid with no outstanding reads → err_orphan_rsp=1 and stays set; assert rst mid-burst → all outputs return to reset values.
